// File: rtl/Purple_Jade_pkg.sv
// Shared types and constants for the Purple_Jade issue/execute slice.
package Purple_Jade_pkg;

  localparam int unsigned WORD_SIZE_P = 16;
  localparam int unsigned TAG_W       = 4;
  localparam int unsigned OPCODE_W    = 4;
  localparam int unsigned CDB_DEST_W  = 6;
  localparam int unsigned NUM_FU      = 4;
  localparam int unsigned FU_MUL      = 2;

  localparam logic [OPCODE_W-1:0] MUL_OP_LO   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] MUL_OP_HI_S = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] MUL_OP_HI_U = OPCODE_W'(2);

  typedef struct packed {
    logic [OPCODE_W-1:0]    opcode;
    logic [TAG_W-1:0]       dest_id;
    logic                   w_v;
    logic [WORD_SIZE_P-1:0] source_1_data;
    logic                   source_1_v;
    logic [WORD_SIZE_P-1:0] source2_imm_data;
    logic                   source_2_v;
  } issued_instruction_t;

  typedef struct packed {
    logic                   valid;
    logic [CDB_DEST_W-1:0]  dest;
    logic [WORD_SIZE_P-1:0] result;
  } CDB_t;

  // Per-stage payload carried down the multiply pipeline.
  typedef struct packed {
    logic [CDB_DEST_W-1:0]  dest;
    logic [WORD_SIZE_P-1:0] result;
  } mul_payload_t;

endpackage

// File: rtl/mul_pipe_stage.sv
// One valid+payload pipeline register; payload is zeroed whenever the stage is invalid.
module mul_pipe_stage #(
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 valid_o,
  output logic [PAYLOAD_W-1:0] payload_o
);

  logic                 valid_d, valid_q;
  logic [PAYLOAD_W-1:0] payload_d, payload_q;

  always_comb begin
    valid_d   = valid_i & ~flush_i;
    payload_d = '0;
    if (valid_d) payload_d = payload_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/mul_fu.sv
// Fully pipelined integer multiply unit driving one CDB slot after LATENCY_P cycles.
// Optional flush_i squash port enabled by defining PJ_MUL_FLUSH_EN.
module mul_fu
  import Purple_Jade_pkg::*;
#(
  parameter int unsigned WORD_SIZE_P = Purple_Jade_pkg::WORD_SIZE_P,
  parameter int unsigned LATENCY_P   = 3
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  issued_instruction_t instruction_i,
  input  logic                valid_i,
  output CDB_t                cdb_o,
  output logic                busy_o
`ifdef PJ_MUL_FLUSH_EN
  ,
  input  logic                flush_i
`endif
);

  localparam int unsigned W         = WORD_SIZE_P;
  localparam int unsigned PAYLOAD_W = $bits(mul_payload_t);

  logic                   flush_c;
  logic signed [2*W-1:0]  a_ext_c, b_ext_c, prod_c;
  logic                   sign_ext_c, take_hi_c;
  mul_payload_t           payload_c;
  mul_payload_t           out_pl_c;
  logic                   busy_d, busy_q;
  logic                   unused_c;

  logic                   stg_v  [LATENCY_P+1];
  logic [PAYLOAD_W-1:0]   stg_pl [LATENCY_P+1];

`ifdef PJ_MUL_FLUSH_EN
  assign flush_c = flush_i;
`else
  assign flush_c = 1'b0;
`endif

  // Readiness and write-enable bits are guaranteed by the issue table.
  assign unused_c = ^{instruction_i.source_1_v, instruction_i.source_2_v, instruction_i.w_v};

  // Only HI_S sign-extends; the low half is identical either way.
  always_comb begin
    sign_ext_c = (instruction_i.opcode == MUL_OP_HI_S);
    take_hi_c  = (instruction_i.opcode == MUL_OP_HI_S) || (instruction_i.opcode == MUL_OP_HI_U);
    a_ext_c    = sign_ext_c ? {{W{instruction_i.source_1_data[W-1]}}, instruction_i.source_1_data}
                            : {{W{1'b0}}, instruction_i.source_1_data};
    b_ext_c    = sign_ext_c ? {{W{instruction_i.source2_imm_data[W-1]}}, instruction_i.source2_imm_data}
                            : {{W{1'b0}}, instruction_i.source2_imm_data};
    prod_c     = a_ext_c * b_ext_c;
    payload_c.dest   = CDB_DEST_W'(instruction_i.dest_id);
    payload_c.result = take_hi_c ? prod_c[2*W-1:W] : prod_c[W-1:0];
  end

  assign stg_v[0]  = valid_i;
  assign stg_pl[0] = payload_c;

  for (genvar i = 0; i < LATENCY_P; i++) begin : g_stage
    mul_pipe_stage #(
      .PAYLOAD_W (PAYLOAD_W)
    ) u_stage (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .flush_i   (flush_c),
      .valid_i   (stg_v[i]),
      .payload_i (stg_pl[i]),
      .valid_o   (stg_v[i+1]),
      .payload_o (stg_pl[i+1])
    );
  end

  // busy mirrors the OR of the stage valids as they will be after this edge.
  always_comb begin
    busy_d = 1'b0;
    for (int unsigned i = 0; i < LATENCY_P; i++) busy_d = busy_d | stg_v[i];
    busy_d = busy_d & ~flush_c;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) busy_q <= 1'b0;
    else            busy_q <= busy_d;
  end

  assign out_pl_c     = mul_payload_t'(stg_pl[LATENCY_P]);
  assign cdb_o.valid  = stg_v[LATENCY_P];
  assign cdb_o.dest   = out_pl_c.dest;
  assign cdb_o.result = out_pl_c.result;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_mul_fu.sv
// Scoreboard bench for mul_fu: driver queues expected beats, negedge monitor checks them.
module tb_mul_fu;
  import Purple_Jade_pkg::*;

  localparam int unsigned LAT = 3;

  typedef struct {
    int               exp_at;
    logic [CDB_DEST_W-1:0] dest;
    logic [15:0]      result;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                valid;
  issued_instruction_t instr;
  CDB_t                cdb;
  logic                busy;
`ifdef PJ_MUL_FLUSH_EN
  logic                flush;
`endif

  int   edge_cnt = 0;
  int   n_cmp    = 0;
  int   n_err    = 0;
  exp_t q[$];

  mul_fu #(
    .WORD_SIZE_P (16),
    .LATENCY_P   (LAT)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (rst_n),
    .instruction_i (instr),
    .valid_i       (valid),
    .cdb_o         (cdb),
    .busy_o        (busy)
`ifdef PJ_MUL_FLUSH_EN
    ,
    .flush_i       (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor: pops the scoreboard on every beat and checks the idle/busy state otherwise.
  always @(negedge clk) begin
    logic exp_busy;
    exp_t e;
    exp_busy = 1'b0;
    foreach (q[i])
      if ((q[i].exp_at - int'(LAT) + 1 <= edge_cnt) && (edge_cnt <= q[i].exp_at)) exp_busy = 1'b1;
    chk("busy", 32'(busy), 32'(exp_busy));
    if (cdb.valid) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 32'(cdb.valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("beat_time", 32'(edge_cnt), 32'(e.exp_at));
        chk("beat_dest", 32'(cdb.dest), 32'(e.dest));
        chk("beat_result", 32'(cdb.result), 32'(e.result));
      end
    end else begin
      chk("idle_zero", {cdb.dest, cdb.result}, 32'd0);
      if (q.size() > 0 && q[0].exp_at <= edge_cnt) begin
        chk("missing_beat", 32'(cdb.valid), 32'd1);
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] dest, input logic [15:0] res);
    instr.opcode           = op;
    instr.dest_id          = dest;
    instr.w_v              = 1'b1;
    instr.source_1_data    = a;
    instr.source_1_v       = 1'b1;
    instr.source2_imm_data = b;
    instr.source_2_v       = 1'b1;
    valid                  = 1'b1;
    q.push_back('{exp_at: edge_cnt + int'(LAT), dest: CDB_DEST_W'(dest), result: res});
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    instr = '0;
`ifdef PJ_MUL_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_cdb", 32'(cdb), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle(1);

    issue(MUL_OP_LO, 16'h0003, 16'h0005, 4'd7, 16'h000F);
    idle(4);

    issue(MUL_OP_HI_S, 16'hFFFF, 16'h0002, 4'd1, 16'hFFFF);
    issue(MUL_OP_HI_U, 16'hFFFF, 16'h0002, 4'd2, 16'h0001);
    issue(MUL_OP_LO,   16'hFFFF, 16'h0002, 4'd3, 16'hFFFE);
    issue(MUL_OP_HI_S, 16'hFFFF, 16'hFFFF, 4'd4, 16'h0000);
    issue(MUL_OP_HI_U, 16'hFFFF, 16'hFFFF, 4'd5, 16'hFFFE);
    issue(MUL_OP_LO,   16'hFFFF, 16'hFFFF, 4'd6, 16'h0001);
    issue(MUL_OP_HI_S, 16'h8000, 16'h7FFF, 4'd8, 16'hC000);
    issue(4'hF,        16'h1234, 16'h0100, 4'hF, 16'h3400);
    idle(4);

    for (int d = 1; d <= 5; d++)
      issue(MUL_OP_LO, 16'(d), 16'h0010, 4'(d), 16'(d * 16));
    idle(4);

    issue(MUL_OP_LO, 16'h0002, 16'h0003, 4'd9, 16'h0006);
    idle(1);
    issue(MUL_OP_LO, 16'h0004, 16'h0003, 4'd10, 16'h000C);
    idle(4);

    // Reset while one beat is on the CDB and two more ops are still in flight.
    issue(MUL_OP_LO, 16'h0007, 16'h0007, 4'd11, 16'h0031);
    issue(MUL_OP_LO, 16'h0001, 16'h0001, 4'd12, 16'h0001);
    issue(MUL_OP_LO, 16'h0002, 16'h0002, 4'd13, 16'h0004);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_reset_cdb", 32'(cdb), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);

`ifdef PJ_MUL_FLUSH_EN
    begin
      int   fl_d;
      exp_t keep[$];
      issue(MUL_OP_LO, 16'h0003, 16'h0003, 4'd1, 16'h0009);
      issue(MUL_OP_LO, 16'h0003, 16'h0004, 4'd2, 16'h000C);
      issue(MUL_OP_LO, 16'h0003, 16'h0005, 4'd3, 16'h000F);
      fl_d                   = edge_cnt;
      flush                  = 1'b1;
      instr.opcode           = MUL_OP_LO;
      instr.dest_id          = 4'd4;
      instr.source_1_data    = 16'h0003;
      instr.source2_imm_data = 16'h0006;
      valid                  = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      valid = 1'b0;
      foreach (q[i]) if (q[i].exp_at <= fl_d) keep.push_back(q[i]);
      q = keep;
      @(negedge clk);
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_cdb", 32'(cdb.valid), 32'd0);
      idle(4);
      issue(MUL_OP_HI_U, 16'h8000, 16'h0004, 4'd5, 16'h0002);
      idle(1);
    end
`endif

    issue(MUL_OP_HI_U, 16'hF000, 16'h0010, 4'd14, 16'h000F);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    chk("drain_empty", 32'(q.size()), 32'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
